// File: rtl/rsa_modexp_if.sv
// Handshake and operand bundle for rsa_modexp.
// master drives en/start/P/E/M/Const; slave returns busy/eoc/C.
interface rsa_modexp_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             start;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] E;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] Const;
  logic             busy;
  logic             eoc;
  logic [WIDTH-1:0] C;

  modport master (
    output en, start, P, E, M, Const,
    input  busy, eoc, C
  );

  modport slave (
    input  en, start, P, E, M, Const,
    output busy, eoc, C
  );
endinterface

// File: rtl/rsa_modexp.sv
// Modular exponentiation C = M^E mod P using bit-serial Montgomery products.
// Ports: clk, rst (sync, active-high), bus (rsa_modexp_if.slave).
module rsa_modexp #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  rsa_modexp_if.slave bus
);
  localparam int SW = WIDTH + 2;
  localparam int JW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] UNIT = 1;

  typedef enum logic [2:0] {
    IDLE, MM_MBAR, MM_ONE, SQR, MUL, FINAL, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [JW-1:0]    j_q, j_d;
  logic [IW-1:0]    i_q, i_d;
  logic [SW-1:0]    s_q, s_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] mbar_q, mbar_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] c_q, c_d;

  logic [WIDTH-1:0] x_op, y_op, x_sh, res;
  logic [SW:0]      s_sum;
  logic [SW-1:0]    s_nxt, s_corr, p_ext;
  logic             mm_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      i_q     <= '0;
      s_q     <= '0;
      p_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      mbar_q  <= '0;
      a_q     <= '0;
      c_q     <= '0;
    end else if (bus.en) begin
      state_q <= state_d;
      j_q     <= j_d;
      i_q     <= i_d;
      s_q     <= s_d;
      p_q     <= p_d;
      e_q     <= e_d;
      m_q     <= m_d;
      k_q     <= k_d;
      mbar_q  <= mbar_d;
      a_q     <= a_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    i_d     = i_q;
    s_d     = s_q;
    p_d     = p_q;
    e_d     = e_q;
    m_d     = m_q;
    k_d     = k_q;
    mbar_d  = mbar_q;
    a_d     = a_q;
    c_d     = c_q;
    x_op    = '0;
    y_op    = '0;

    unique case (state_q)
      MM_MBAR: begin x_op = m_q;  y_op = k_q;    end
      MM_ONE:  begin x_op = UNIT; y_op = k_q;    end
      SQR:     begin x_op = a_q;  y_op = a_q;    end
      MUL:     begin x_op = a_q;  y_op = mbar_q; end
      FINAL:   begin x_op = a_q;  y_op = UNIT;   end
      default: ;
    endcase

    // One Montgomery step: add X[j]*Y, make even with P, halve.
    x_sh  = x_op >> j_q;
    p_ext = {2'b00, p_q};
    s_sum = {1'b0, s_q}
          + (x_sh[0] ? {3'b000, y_op} : '0);
    if (s_sum[0])
      s_sum = s_sum + {1'b0, p_ext};
    s_nxt   = s_sum[SW:1];
    s_corr  = (s_q >= p_ext) ? s_q - p_ext : s_q;
    res     = s_corr[WIDTH-1:0];
    mm_last = (j_q == JW'(WIDTH));

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          p_d     = bus.P;
          e_d     = bus.E;
          m_d     = bus.M;
          k_d     = bus.Const;
          s_d     = '0;
          j_d     = '0;
          state_d = MM_MBAR;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (!mm_last) begin
          s_d = s_nxt;
          j_d = j_q + JW'(1);
        end else begin
          // Correction cycle also decides the next product.
          s_d = '0;
          j_d = '0;
          unique case (state_q)
            MM_MBAR: begin
              mbar_d  = res;
              state_d = MM_ONE;
            end
            MM_ONE: begin
              a_d     = res;
              i_d     = IW'(WIDTH - 1);
              state_d = SQR;
            end
            FINAL: begin
              c_d     = res;
              state_d = DONE;
            end
            default: begin
              a_d = res;
              if (state_q == SQR && e_q[i_q]) begin
                state_d = MUL;
              end else if (i_q != '0) begin
                i_d     = i_q - IW'(1);
                state_d = SQR;
              end else begin
                state_d = FINAL;
              end
            end
          endcase
        end
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.eoc  = (state_q == DONE);
  assign bus.C    = c_q;
endmodule

// File: doc/rsa_modexp.md
RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand, modulus and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port en  input  1  clock enable; when 0, all registers hold their value.
REQ-005 SHALL have port start  input  1  request pulse, sampled only in IDLE while en=1.
REQ-006 SHALL have port P  input  WIDTH  modulus; odd and >= 3.
REQ-007 SHALL have port E  input  WIDTH  exponent.
REQ-008 SHALL have port M  input  WIDTH  message; any value 0..2^WIDTH-1.
REQ-009 SHALL have port Const  input  WIDTH  Montgomery constant R^2 mod P, where R=2^WIDTH.
REQ-010 SHALL have port busy  output  1  high from the cycle after start is accepted until IDLE is re-entered.
REQ-011 SHALL have port eoc  output  1  one-cycle end-of-computation pulse.
REQ-012 SHALL have port C  output  WIDTH  result M^E mod P; held until the next eoc.

Function
REQ-013 SHALL latch P, E, M and Const on the edge that accepts start; later input changes SHALL NOT affect the running operation.
REQ-014 SHALL use bit-serial Montgomery multiplication MM(X,Y) = X*Y*R^-1 mod P:
- S=0.
- For j=0..WIDTH-1: S=S+X[j]*Y; if S is odd, S=S+P; S=S>>1. One cycle per j.
- One correction cycle: if S>=P, S=S-P.
- Total WIDTH+1 cycles.
REQ-015 SHALL size the accumulator S at WIDTH+2 bits so no intermediate value overflows.
REQ-016 SHALL implement FSM states IDLE, MM_MBAR, MM_ONE, SQR, MUL, FINAL, DONE.
REQ-017 Transitions SHALL be:
- IDLE->MM_MBAR on accepted start; MM_MBAR computes Mbar=MM(M,Const).
- MM_MBAR->MM_ONE; MM_ONE computes A=MM(1,Const).
- MM_ONE->SQR with bit index i=WIDTH-1.
- SQR computes A=MM(A,A), then goes to MUL if E[i]=1, else ends the bit.
- MUL computes A=MM(A,Mbar), then ends the bit.
- Bit end: if i>0, decrement i and go to SQR; if i=0, go to FINAL.
- FINAL computes C=MM(A,1), then goes to DONE.
- DONE->IDLE after exactly one cycle.
REQ-018 SHALL update C only on the FINAL->DONE edge and assert eoc only during DONE.
REQ-019 SHALL make latency deterministic: eoc rises exactly (WIDTH+1)*(WIDTH+3+popcount(E)) enabled cycles after the edge that accepts start.
REQ-020 SHALL ignore start while busy=1 or in DONE; a new start SHALL be accepted in IDLE on the cycle after DONE.
REQ-021 With en=0, SHALL freeze the FSM, counters and datapath; eoc SHALL stay high if frozen in DONE, and latency counts enabled cycles only.
REQ-022 E=0 SHALL yield C=1; M=0 with E!=0 SHALL yield C=0.
REQ-023 Results for even P, P<3 or Const != R^2 mod P are unspecified, but the FSM SHALL still complete and return to IDLE.

Reset
REQ-024 While rst=1, SHALL force state=IDLE, busy=0, eoc=0, C=0, and clear all internal registers to 0; rst SHALL take priority over en.
REQ-025 rst asserted mid-operation SHALL abort within one cycle with no eoc; the next start SHALL run a full fresh computation.

Verification
REQ-026 WIDTH=8, P=11, Const=9, M=5, E=3, start pulse -> eoc after 9*13=117 cycles, C=4; busy falls with eoc.
REQ-027 P=251, Const=25, M=2, E=0x08 -> C=5 after 9*12=108 cycles; M=20, P=11, Const=9, E=1 -> C=9.
REQ-028 E=0, any M, P=11, Const=9 -> C=1 after 99 cycles; M=0, E=5 -> C=0.
REQ-029 Re-pulse start and change inputs mid-run -> result and latency unchanged; back-to-back start in the cycle after DONE is accepted.
REQ-030 Drop en for 10 cycles mid-run -> eoc delayed by exactly 10 cycles with the same C; assert rst mid-run -> busy=0, C=0, no eoc.
REQ-031 Random odd P, M, E with host-computed Const -> C matches the reference pow(M,E,P) over 1000 vectors.
